instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the program counter and drives the word address into the
//  combinational instruction memory (address[3:0] -> instruction[31:0], zero read latency).
//  Registers the returned word into the IF/ID pipeline register. Handles stall, branch/jump
//  redirect with a one-bubble squash, and a halt state. Sits between IM and the decode stage.
// PARAMETERS
//  ADDR_W     4             PC / IM word-address width; PC arithmetic is modulo 2**ADDR_W
//  INST_W     32            instruction width
//  RESET_PC   0             PC value loaded on reset
//  HALT_INST  32'hFFFF_FFFF instruction word that sends the FSM to HALT
//  CNT_W      16            width of fetch_count
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous, active-high reset
//  stall          in   1       decode back-pressure; hold PC and IF/ID
//  branch_taken   in   1       beq resolved taken this cycle
//  branch_target  in   ADDR_W  branch destination word address
//  jump           in   1       j decoded this cycle
//  jump_target    in   ADDR_W  jump destination word address
//  im_address     out  ADDR_W  address to IM; combinationally equal to pc
//  im_instruction in   INST_W  word returned by IM for im_address
//  if_id_instr    out  INST_W  registered instruction to decode
//  if_id_pc1      out  ADDR_W  registered PC+1 of that instruction (branch base)
//  if_id_valid    out  1       if_id_instr is a real fetched instruction
//  halted         out  1       FSM in HALT
//  fetch_count    out  CNT_W   number of valid instructions issued, saturating
// BEHAVIOUR
//  Reset (rst=1 at edge): pc=RESET_PC, if_id_instr=0, if_id_pc1=0, if_id_valid=0, halted=0,
//   fetch_count=0, state=BOOT. rst dominates all other inputs; asserting it mid-run discards
//   in-flight state on the same edge.
//  States: BOOT -> RUN on the first edge after reset (IF/ID stays invalid during BOOT).
//   RUN -> HALT when an accepted fetch has im_instruction==HALT_INST. HALT exits only on rst.
//  Per-edge priority in RUN: rst > redirect > stall > sequential.
//   redirect = jump | branch_taken; target = jump ? jump_target : branch_target (jump wins).
//   redirect: pc<=target; IF/ID <= bubble (instr=0, pc1=0, valid=0); applies even if stall=1.
//   stall (no redirect): pc, if_id_* and fetch_count hold.
//   sequential: if_id_instr<=im_instruction, if_id_pc1<=pc+1, if_id_valid<=1, pc<=pc+1.
//  Fetch latency: the word at pc appears on if_id_instr one edge after being addressed.
//  pc+1 wraps (2**ADDR_W-1)+1 -> 0; if_id_pc1 wraps identically.
//  HALT_INST fetched in the same cycle as a redirect is wrong-path: redirect wins, no halt.
//  An accepted HALT_INST is issued to IF/ID as valid (counted); from the next edge
//   pc freezes, if_id_valid=0, halted=1; stall/redirect ignored in HALT.
//  fetch_count increments on every edge that writes if_id_valid=1; saturates at 2**CNT_W-1.
//  im_address never glitches to target mid-cycle: it only changes on clk edges.
// TESTING
//  1 rst 2 cycles, release, IM rom[i]=i+0x100 -> im_address 0,1,2,3; if_id_instr 0x100,0x101
//    one cycle behind; if_id_valid 0 in first cycle after release; fetch_count=3 after 4 edges.
//  2 run from pc=14 -> im_address 14,15,0,1; if_id_pc1 15,0,1 (wrap both).
//  3 stall=1 for 3 cycles at pc=5 -> pc stays 5, if_id_instr/fetch_count frozen; resume -> 6.
//  4 branch_taken=1 target=9 and jump=1 target=2 same cycle, stall=1 -> pc=2, if_id_valid=0
//    next cycle, then if_id_instr=rom[2].
//  5 rom[4]=HALT_INST, sequential run -> HALT issued valid, halted=1 next edge, pc stuck at 5,
//    if_id_valid=0; same setup with jump at pc=4 -> no halt; rst in HALT -> BOOT, pc=0.
//  6 rst asserted mid-stream with stall=1 and branch_taken=1 -> all outputs at reset values.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational IM and
// registers the fetched word into IF/ID with stall, redirect squash and halt.
module instr_fetch_unit #(
  parameter int unsigned               ADDR_W    = 4,
  parameter int unsigned               INST_W    = 32,
  parameter logic [ADDR_W-1:0]         RESET_PC  = '0,
  parameter logic [INST_W-1:0]         HALT_INST = 32'hFFFF_FFFF,
  parameter int unsigned               CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] im_address,
  input  logic [INST_W-1:0] im_instruction,
  output logic [INST_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc1,
  output logic              if_id_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc1;
  logic [ADDR_W-1:0] w_target;
  logic              w_redirect;
  logic              w_accept;
  logic              w_halt_fetch;

  assign im_address = r_pc;
  assign w_pc1      = r_pc + 1'b1;
  assign w_target   = jump ? jump_target : branch_target;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   if (w_halt_fetch) w_state_nxt = S_HALT;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Redirect outranks stall; a word fetched alongside a redirect is wrong-path.
  always_comb begin
    w_redirect   = 1'b0;
    w_accept     = 1'b0;
    w_halt_fetch = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_RUN: begin
        w_redirect   = jump | branch_taken;
        w_accept     = !(jump | branch_taken) && !stall;
        w_halt_fetch = w_accept && (im_instruction == HALT_INST);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc1   <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else if (w_redirect) begin
      r_pc        <= w_target;
      if_id_instr <= '0;
      if_id_pc1   <= '0;
      if_id_valid <= 1'b0;
    end else if (w_accept) begin
      r_pc        <= w_pc1;
      if_id_instr <= im_instruction;
      if_id_pc1   <= w_pc1;
      if_id_valid <= 1'b1;
      if (fetch_count != '1) fetch_count <= fetch_count + 1'b1;
    end else if (halted) begin
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector bench for instr_fetch_unit: table of per-edge expectations
// plus hand-written halt / wrong-path / reset-in-halt sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump;
  logic [3:0]  branch_target, jump_target;
  logic [3:0]  im_address, im_address2;
  logic [31:0] im_instruction, im_instruction2;
  logic [31:0] if_id_instr, if_id_instr2;
  logic [3:0]  if_id_pc1, if_id_pc12;
  logic        if_id_valid, if_id_valid2, halted, halted2;
  logic [15:0] fetch_count;
  logic [1:0]  fetch_count2;
  logic [31:0] rom [16];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign im_instruction  = rom[im_address];
  assign im_instruction2 = rom[im_address2];

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .im_address(im_address), .im_instruction(im_instruction),
    .if_id_instr(if_id_instr), .if_id_pc1(if_id_pc1), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  // Narrow counter copy exercises saturation within a short run.
  instr_fetch_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .im_address(im_address2), .im_instruction(im_instruction2),
    .if_id_instr(if_id_instr2), .if_id_pc1(if_id_pc12), .if_id_valid(if_id_valid2),
    .halted(halted2), .fetch_count(fetch_count2)
  );

  typedef struct {
    logic        rst, stall, br;
    logic [3:0]  bt;
    logic        j;
    logic [3:0]  jt;
    logic [3:0]  addr;
    logic [31:0] instr;
    logic [3:0]  pc1;
    logic        valid, halted;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic s, input logic br, input logic [3:0] bt,
                       input logic j, input logic [3:0] jt);
    rst = r; stall = s; branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'h100 + i;
    drive(1, 0, 0, 0, 0, 0);

    //          rst st br bt j jt  addr instr        pc1 v h cnt
    vecs[0]  = '{1, 0, 0, 0, 0, 0,  0, 32'h0,       0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0,  0, 32'h0,       0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0,  0, 32'h0,       0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0,  1, 32'h100,     1, 1, 0, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 0,  2, 32'h101,     2, 1, 0, 2};
    vecs[5]  = '{0, 0, 0, 0, 0, 0,  3, 32'h102,     3, 1, 0, 3};
    vecs[6]  = '{0, 0, 0, 0, 0, 0,  4, 32'h103,     4, 1, 0, 4};
    vecs[7]  = '{0, 0, 0, 0, 0, 0,  5, 32'h104,     5, 1, 0, 5};
    vecs[8]  = '{0, 1, 0, 0, 0, 0,  5, 32'h104,     5, 1, 0, 5};
    vecs[9]  = '{0, 1, 0, 0, 0, 0,  5, 32'h104,     5, 1, 0, 5};
    vecs[10] = '{0, 1, 0, 0, 0, 0,  5, 32'h104,     5, 1, 0, 5};
    vecs[11] = '{0, 0, 0, 0, 0, 0,  6, 32'h105,     6, 1, 0, 6};
    vecs[12] = '{0, 1, 1, 9, 1, 2,  2, 32'h0,       0, 0, 0, 6};
    vecs[13] = '{0, 0, 0, 0, 0, 0,  3, 32'h102,     3, 1, 0, 7};
    vecs[14] = '{0, 0, 0, 0, 1, 14, 14, 32'h0,      0, 0, 0, 7};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 15, 32'h10E,    15, 1, 0, 8};
    vecs[16] = '{0, 0, 0, 0, 0, 0,  0, 32'h10F,     0, 1, 0, 9};
    vecs[17] = '{0, 0, 0, 0, 0, 0,  1, 32'h100,     1, 1, 0, 10};
    vecs[18] = '{0, 0, 1, 9, 0, 0,  9, 32'h0,       0, 0, 0, 10};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 10, 32'h109,    10, 1, 0, 11};
    vecs[20] = '{1, 1, 1, 7, 0, 0,  0, 32'h0,       0, 0, 0, 0};
    vecs[21] = '{0, 0, 0, 0, 0, 0,  0, 32'h0,       0, 0, 0, 0};
    vecs[22] = '{0, 0, 0, 0, 0, 0,  1, 32'h100,     1, 1, 0, 1};

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].j, vecs[i].jt);
      step();
      check($sformatf("v%0d im_address", i), 32'(im_address), 32'(vecs[i].addr));
      check($sformatf("v%0d if_id_instr", i), if_id_instr, vecs[i].instr);
      check($sformatf("v%0d if_id_pc1", i), 32'(if_id_pc1), 32'(vecs[i].pc1));
      check($sformatf("v%0d if_id_valid", i), 32'(if_id_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].halted));
      check($sformatf("v%0d fetch_count", i), 32'(fetch_count), 32'(vecs[i].cnt));
      check($sformatf("v%0d sat_count", i), 32'(fetch_count2),
            (vecs[i].cnt > 3) ? 32'd3 : 32'(vecs[i].cnt));
    end

    // Halt: rom[4] is the halt word, reached sequentially from reset.
    rom[4] = 32'hFFFF_FFFF;
    drive(1, 0, 0, 0, 0, 0); step();
    idle_steps(5);
    check("pre-halt pc", 32'(im_address), 32'd4);
    check("pre-halt halted", 32'(halted), 32'd0);
    idle_steps(1);
    check("halt issued instr", if_id_instr, 32'hFFFF_FFFF);
    check("halt issued valid", 32'(if_id_valid), 32'd1);
    check("halt issued count", 32'(fetch_count), 32'd5);
    check("halt issued halted", 32'(halted), 32'd1);
    check("halt issued pc", 32'(im_address), 32'd5);
    idle_steps(1);
    check("halt frozen valid", 32'(if_id_valid), 32'd0);
    check("halt frozen pc", 32'(im_address), 32'd5);
    check("halt frozen count", 32'(fetch_count), 32'd5);
    drive(0, 1, 1, 9, 1, 2); step();
    check("halt ignores redirect pc", 32'(im_address), 32'd5);
    check("halt ignores redirect halted", 32'(halted), 32'd1);

    // Reset out of HALT.
    drive(1, 0, 0, 0, 0, 0); step();
    check("rst in halt pc", 32'(im_address), 32'd0);
    check("rst in halt halted", 32'(halted), 32'd0);
    check("rst in halt count", 32'(fetch_count), 32'd0);

    // Wrong-path halt word: jump taken while rom[4] is on the bus.
    idle_steps(5);
    check("wrong-path pre pc", 32'(im_address), 32'd4);
    drive(0, 0, 0, 0, 1, 1); step();
    check("wrong-path pc", 32'(im_address), 32'd1);
    check("wrong-path valid", 32'(if_id_valid), 32'd0);
    check("wrong-path halted", 32'(halted), 32'd0);
    idle_steps(1);
    check("wrong-path next instr", if_id_instr, 32'h101);
    check("wrong-path next halted", 32'(halted), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
